rob_multi: RTL and testbench

Parametrised reorder buffer, successor to the single-commit ROB. Sits between dispatcher, ALU/LSU writeback buses and regfile. It allocates one in-order entry per cycle, accepts results from `WB_PORTS` writeback buses, serves two operand lookups with writeback bypass, and retires up to `COMMIT_W` entries per cycle in order. Speculative entries are squashed by branch mask on mispredict, and the tail is recovered to the oldest squashed slot.

---
 rtl/rob_pkg.sv | 21 ++
 rtl/rob_multi_if.sv | 51 +++++
 rtl/rob_commit_sel.sv | 23 ++
 rtl/rob_multi.sv | 159 +++++++++++++++
 tb/tb_rob_multi.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared ROB types: tag width helper, entry layout and the branch-mask
// width used by the dispatcher and reservation stations.
package rob_pkg;

    localparam int BR_MASK_W  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int AREG_W     = 5;

    function automatic int tag_w(input int depth);
        return $clog2(depth);
    endfunction

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic [BR_MASK_W-1:0]  br_mask;
        logic [AREG_W-1:0]     dest;
        logic [DATA_W_DEF-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/rob_multi_if.sv
// Dispatch, writeback, lookup, resolve and commit buses of the ROB.
// master = surrounding pipeline, slave = the ROB itself.
interface rob_multi_if #(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = rob_pkg::DATA_W_DEF,
    parameter int BR_W     = rob_pkg::BR_MASK_W,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
);
    localparam int TAG_W = rob_pkg::tag_w(DEPTH);
    localparam int BI_W  = $clog2(BR_W);

    logic                         disp_en;
    logic [BR_W-1:0]              disp_br_mask;
    logic [4:0]                   disp_dest;
    logic [TAG_W-1:0]             disp_tag;
    logic                         rob_free;
    logic [WB_PORTS-1:0]          wb_en;
    logic [WB_PORTS*TAG_W-1:0]    wb_tag;
    logic [WB_PORTS*DATA_W-1:0]   wb_data;
    logic [1:0]                   rd_vld;
    logic [2*TAG_W-1:0]           rd_tag;
    logic [1:0]                   rd_hit;
    logic [2*DATA_W-1:0]          rd_data;
    logic                         br_en;
    logic [BI_W-1:0]              br_idx;
    logic                         br_mis;
    logic [COMMIT_W-1:0]          com_en;
    logic [COMMIT_W*TAG_W-1:0]    com_tag;
    logic [COMMIT_W*5-1:0]        com_dest;
    logic [COMMIT_W*DATA_W-1:0]   com_data;

    modport master (
        output disp_en, disp_br_mask, disp_dest,
        output wb_en, wb_tag, wb_data,
        output rd_vld, rd_tag,
        output br_en, br_idx, br_mis,
        input  disp_tag, rob_free, rd_hit, rd_data,
        input  com_en, com_tag, com_dest, com_data
    );

    modport slave (
        input  disp_en, disp_br_mask, disp_dest,
        input  wb_en, wb_tag, wb_data,
        input  rd_vld, rd_tag,
        input  br_en, br_idx, br_mis,
        output disp_tag, rob_free, rd_hit, rd_data,
        output com_en, com_tag, com_dest, com_data
    );

endinterface

// File: rtl/rob_commit_sel.sv
// Length of the ready run starting at head (bit 0), capped at COMMIT_W.
module rob_commit_sel #(
    parameter int DEPTH    = 16,
    parameter int COMMIT_W = 2,
    parameter int N_W      = 2
) (
    input  logic [DEPTH-1:0] rdy_rot,
    output logic [N_W-1:0]   n
);

    logic run;

    always_comb begin
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            run = run & rdy_rot[i];
            if (run && n < N_W'(COMMIT_W))
                n = n + N_W'(1);
        end
    end

endmodule

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer: in-order allocate, N-port writeback with
// operand bypass, branch-mask squash with tail recovery, wide retire.
module rob_multi
    import rob_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int BR_W     = BR_MASK_W,
    parameter int WB_PORTS = 2,
    parameter int COMMIT_W = 2
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    rob_multi_if.slave bus
);

    localparam int TAG_W = tag_w(DEPTH);
    localparam int CNT_W = TAG_W + 1;
    localparam int N_W   = $clog2(COMMIT_W + 1);

    logic [DEPTH-1:0]          vld, done;
    logic [BR_W-1:0]           mask  [DEPTH];
    logic [BR_W-1:0]           nmask [DEPTH];
    logic [4:0]                dest  [DEPTH];
    logic [DATA_W-1:0]         data  [DEPTH];
    logic [TAG_W-1:0]          head, tail, idx;
    logic [CNT_W-1:0]          count, sq_off, base;
    logic [CNT_W:0]            occ;
    logic [BR_W-1:0]           clr;
    logic [DEPTH-1:0]          sq, ready, rot;
    logic [N_W-1:0]            ncom;
    logic                      mis, disp_ok;
    logic [TAG_W-1:0]          rt;
    logic [1:0]                hit;
    logic [2*DATA_W-1:0]       rdat;
    logic [COMMIT_W-1:0]       com_en_q;
    logic [COMMIT_W*TAG_W-1:0] com_tag_q;
    logic [COMMIT_W*5-1:0]     com_dest_q;
    logic [COMMIT_W*DATA_W-1:0] com_data_q;

    assign mis     = bus.br_en & bus.br_mis;
    assign clr     = bus.br_en ? ~(BR_W'(1) << bus.br_idx) : '1;
    assign disp_ok = bus.disp_en & (count < CNT_W'(DEPTH)) & ~mis;
    assign occ     = {1'b0, count} + (CNT_W + 1)'(bus.disp_en);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            nmask[i] = mask[i] & clr;
            sq[i]    = mis & vld[i] & mask[i][bus.br_idx];
            ready[i] = vld[i] & done[i] & ~sq[i] & (nmask[i] == '0);
        end
        idx    = head;
        rot    = '0;
        sq_off = count;
        // Downward scan leaves the squashed entry closest to head
        for (int j = DEPTH - 1; j >= 0; j--) begin
            idx    = head + TAG_W'(j);
            rot[j] = ready[idx];
            if (sq[idx])
                sq_off = CNT_W'(j);
        end
        base = mis ? sq_off : count;
    end

    rob_commit_sel #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W),
        .N_W      (N_W)
    ) u_sel (
        .rdy_rot (rot),
        .n       (ncom)
    );

    always_comb begin
        hit  = '0;
        rdat = '0;
        rt   = '0;
        for (int k = 0; k < 2; k++) begin
            rt = bus.rd_tag[k*TAG_W +: TAG_W];
            if (vld[rt] && done[rt]) begin
                hit[k]                    = 1'b1;
                rdat[k*DATA_W +: DATA_W]  = data[rt];
            end
            // Highest port first so the lowest matching port wins
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (bus.wb_en[p] && bus.wb_tag[p*TAG_W +: TAG_W] == rt) begin
                    hit[k]                   = 1'b1;
                    rdat[k*DATA_W +: DATA_W] = bus.wb_data[p*DATA_W +: DATA_W];
                end
            end
            hit[k] = hit[k] & bus.rd_vld[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            vld        <= '0;
            done       <= '0;
            com_en_q   <= '0;
            com_tag_q  <= '0;
            com_dest_q <= '0;
            com_data_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mask[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++)
                mask[i] <= nmask[i];
            for (int p = 0; p < WB_PORTS; p++) begin
                if (bus.wb_en[p] && vld[bus.wb_tag[p*TAG_W +: TAG_W]]) begin
                    done[bus.wb_tag[p*TAG_W +: TAG_W]] <= 1'b1;
                    data[bus.wb_tag[p*TAG_W +: TAG_W]] <=
                        bus.wb_data[p*DATA_W +: DATA_W];
                end
            end
            for (int l = 0; l < COMMIT_W; l++) begin
                com_en_q[l] <= N_W'(l) < ncom;
                if (N_W'(l) < ncom) begin
                    vld[head + TAG_W'(l)]  <= 1'b0;
                    done[head + TAG_W'(l)] <= 1'b0;
                    com_tag_q[l*TAG_W +: TAG_W]    <= head + TAG_W'(l);
                    com_dest_q[l*5 +: 5]           <= dest[head + TAG_W'(l)];
                    com_data_q[l*DATA_W +: DATA_W] <= data[head + TAG_W'(l)];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (sq[i]) begin
                    vld[i]  <= 1'b0;
                    done[i] <= 1'b0;
                end
            end
            if (disp_ok) begin
                vld[tail]  <= 1'b1;
                done[tail] <= 1'b0;
                mask[tail] <= bus.disp_br_mask & clr;
                dest[tail] <= bus.disp_dest;
            end
            head  <= head + TAG_W'(ncom);
            count <= base - CNT_W'(ncom) + CNT_W'(disp_ok);
            if (mis)
                tail <= head + sq_off[TAG_W-1:0];
            else if (disp_ok)
                tail <= tail + TAG_W'(1);
        end
    end

    assign bus.disp_tag = tail;
    assign bus.rob_free = occ < (CNT_W + 1)'(DEPTH);
    assign bus.rd_hit   = hit;
    assign bus.rd_data  = rdat;
    assign bus.com_en   = com_en_q;
    assign bus.com_tag  = com_tag_q;
    assign bus.com_dest = com_dest_q;
    assign bus.com_data = com_data_q;

endmodule

// File: tb/tb_rob_multi.sv
// Scoreboard bench for rob_multi: dispatch pushes tags, commits pop them.
module tb_rob_multi;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    rob_multi_if #(.DEPTH(16), .DATA_W(32), .BR_W(4),
                   .WB_PORTS(2), .COMMIT_W(2)) bus ();

    rob_multi #(.DEPTH(16), .DATA_W(32), .BR_W(4),
                .WB_PORTS(2), .COMMIT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int pairs    = 0;

    logic [3:0]  q[$];
    logic [3:0]  exp_tail;
    logic [4:0]  exp_dest [DEPTH];
    logic [31:0] exp_data [DEPTH];
    logic [3:0]  mon_t;

    task automatic chk(input string nm, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", nm, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_en      = 1'b0;
        bus.disp_br_mask = '0;
        bus.disp_dest    = '0;
        bus.wb_en        = '0;
        bus.wb_tag       = '0;
        bus.wb_data      = '0;
        bus.rd_vld       = '0;
        bus.rd_tag       = '0;
        bus.br_en        = 1'b0;
        bus.br_idx       = '0;
        bus.br_mis       = 1'b0;
    endtask

    task automatic disp(input logic [4:0] d, input logic [3:0] m,
                        input logic free_exp);
        bus.disp_en      = 1'b1;
        bus.disp_br_mask = m;
        bus.disp_dest    = d;
        #1;
        chk("disp_tag", 64'(bus.disp_tag), 64'(exp_tail));
        chk("rob_free", 64'(bus.rob_free), 64'(free_exp));
        q.push_back(exp_tail);
        exp_dest[exp_tail] = d;
        exp_tail = exp_tail + 4'd1;
        cyc();
        bus.disp_en = 1'b0;
    endtask

    task automatic wb(input logic [1:0] en, input logic [3:0] t0,
                      input logic [3:0] t1, input logic [31:0] d0,
                      input logic [31:0] d1);
        bus.wb_en   = en;
        bus.wb_tag  = {t1, t0};
        bus.wb_data = {d1, d0};
        if (en[0]) exp_data[t0] = d0;
        if (en[1]) exp_data[t1] = d1;
        cyc();
        bus.wb_en = '0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            cyc();
            n++;
        end
        chk(nm, 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        cyc();
        cyc();
        rst = 1'b0;
        q.delete();
        exp_tail = '0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.com_en != 2'b00) begin
            chk("com_contig", 64'(bus.com_en), 64'(bus.com_en == 2'b10 ? 2'b11 : bus.com_en));
            if (bus.com_en == 2'b11) pairs++;
            for (int l = 0; l < 2; l++) begin
                if (bus.com_en[l]) begin
                    if (q.size() == 0) begin
                        chk("com_extra", 64'(bus.com_en), 64'd0);
                    end else begin
                        mon_t = q.pop_front();
                        chk("com_tag", 64'(bus.com_tag[l*4 +: 4]), 64'(mon_t));
                        chk("com_dest", 64'(bus.com_dest[l*5 +: 5]), 64'(exp_dest[mon_t]));
                        chk("com_data", 64'(bus.com_data[l*32 +: 32]), 64'(exp_data[mon_t]));
                    end
                end
            end
        end
    end

    initial begin
        rdy = 1'b1;
        do_reset();
        chk("rst_com_en", 64'(bus.com_en), 64'd0);
        chk("rst_com_tag", 64'(bus.com_tag), 64'd0);
        chk("rst_com_data", 64'(bus.com_data), 64'd0);
        chk("rst_disp_tag", 64'(bus.disp_tag), 64'd0);
        chk("rst_free", 64'(bus.rob_free), 64'd1);
        chk("rst_count", 64'(dut.count), 64'd0);

        // Fill to capacity
        for (int i = 0; i < DEPTH; i++)
            disp(5'(i), 4'b0000, i < DEPTH - 1);
        chk("full_free", 64'(bus.rob_free), 64'd0);
        chk("full_count", 64'(dut.count), 64'd16);
        bus.disp_en = 1'b1;
        bus.disp_dest = 5'd31;
        cyc();
        bus.disp_en = 1'b0;
        chk("ovf_count", 64'(dut.count), 64'd16);
        chk("ovf_tail", 64'(bus.disp_tag), 64'd0);

        // Stalled writeback must not land
        rdy = 1'b0;
        wb(2'b11, 4'd0, 4'd1, 32'hBAD0, 32'hBAD1);
        rdy = 1'b1;
        bus.rd_vld = 2'b01;
        bus.rd_tag = {4'd0, 4'd0};
        #1;
        chk("stall_wb", 64'(bus.rd_hit), 64'd0);
        bus.rd_vld = '0;

        for (int c = 0; c < 8; c++)
            wb(2'b11, 4'(2*c), 4'(2*c+1), 32'h1000 + 32'(2*c),
               32'h1000 + 32'(2*c+1));
        drain("fill_drain");
        chk("pairs", 64'(pairs), 64'd8);
        chk("drain_count", 64'(dut.count), 64'd0);
        chk("drain_head", 64'(dut.head), 64'd0);
        chk("drain_tail", 64'(bus.disp_tag), 64'd0);

        // Move head to 3, then partial commit
        for (int i = 0; i < 3; i++)
            disp(5'(20 + i), 4'b0000, 1'b1);
        wb(2'b11, 4'd0, 4'd1, 32'h20, 32'h21);
        wb(2'b01, 4'd2, 4'd0, 32'h22, 32'h0);
        drain("head3_drain");
        for (int i = 3; i < 8; i++)
            disp(5'(i), 4'b0000, 1'b1);
        wb(2'b11, 4'd3, 4'd5, 32'h33, 32'h55);
        cyc();
        chk("part_lane0", 64'(bus.com_en), 64'b01);
        cyc();
        chk("part_wait", 64'(bus.com_en), 64'b00);
        wb(2'b01, 4'd4, 4'd0, 32'h44, 32'h0);
        cyc();
        chk("part_pair", 64'(bus.com_en), 64'b11);

        // Bypass on port 1 while entry 6 stays pending
        bus.rd_vld  = 2'b11;
        bus.rd_tag  = {4'd6, 4'd7};
        bus.wb_en   = 2'b10;
        bus.wb_tag  = {4'd7, 4'd0};
        bus.wb_data = {32'hDEAD, 32'h0};
        exp_data[7] = 32'hDEAD;
        #1;
        chk("byp_hit", 64'(bus.rd_hit), 64'b01);
        chk("byp_data", 64'(bus.rd_data[31:0]), 64'hDEAD);
        cyc();
        bus.wb_en = '0;
        #1;
        chk("rd_hit", 64'(bus.rd_hit), 64'b01);
        chk("rd_data", 64'(bus.rd_data[31:0]), 64'hDEAD);
        bus.rd_vld = '0;
        #1;
        chk("rd_novld", 64'(bus.rd_hit), 64'b00);
        wb(2'b01, 4'd6, 4'd0, 32'h66, 32'h0);
        drain("byp_drain");

        // Mispredict: squash 6..9 with a simultaneous (ignored) dispatch
        do_reset();
        disp(5'd1, 4'b0000, 1'b1);
        disp(5'd2, 4'b0000, 1'b1);
        wb(2'b11, 4'd0, 4'd1, 32'h100, 32'h101);
        drain("mis_pre");
        for (int i = 2; i < 10; i++)
            disp(5'(i), i >= 6 ? 4'b0010 : 4'b0000, 1'b1);
        bus.br_en     = 1'b1;
        bus.br_idx    = 2'd1;
        bus.br_mis    = 1'b1;
        bus.disp_en   = 1'b1;
        bus.disp_dest = 5'd9;
        cyc();
        idle();
        repeat (4) void'(q.pop_back());
        exp_tail = 4'd6;
        chk("mis_count", 64'(dut.count), 64'd4);
        chk("mis_tail", 64'(bus.disp_tag), 64'd6);
        wb(2'b01, 4'd8, 4'd0, 32'hBAD, 32'h0);
        bus.rd_vld = 2'b01;
        bus.rd_tag = {4'd0, 4'd8};
        #1;
        chk("mis_drop", 64'(bus.rd_hit), 64'd0);
        bus.rd_vld = '0;
        disp(5'd17, 4'b0000, 1'b1);
        chk("mis_count5", 64'(dut.count), 64'd5);

        // Reset while a commit of 2,3 is due
        wb(2'b11, 4'd2, 4'd3, 32'h202, 32'h303);
        rst = 1'b1;
        cyc();
        chk("mid_rst_com", 64'(bus.com_en), 64'd0);
        chk("mid_rst_count", 64'(dut.count), 64'd0);
        chk("mid_rst_tail", 64'(bus.disp_tag), 64'd0);
        rst = 1'b0;
        q.delete();
        exp_tail = '0;

        // Correct resolve frees a done head in the same update
        disp(5'd11, 4'b0010, 1'b1);
        wb(2'b01, 4'd0, 4'd0, 32'hAAAA, 32'h0);
        cyc();
        cyc();
        chk("blocked", 64'(bus.com_en), 64'd0);
        bus.br_en  = 1'b1;
        bus.br_idx = 2'd1;
        bus.br_mis = 1'b0;
        disp(5'd12, 4'b0010, 1'b1);
        idle();
        chk("res_commit", 64'(bus.com_en), 64'b01);
        wb(2'b01, 4'd1, 4'd0, 32'hBBBB, 32'h0);
        drain("res_drain");
        chk("end_count", 64'(dut.count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule
